// File: rtl/cache_lru_sched.sv
// Two-port scheduler sharing one 4-way cache_LRU: TOUCH issues in one cycle, VICTIM reads then marks used.
// Define CACHE_LRU_SCHED_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module cache_lru_sched #(
    parameter int ADDR_W = 9,
    parameter int WAY_W  = 2
) (
    input  logic              main_clk,
    input  logic              main_rst_n,
    input  logic              req0,
    input  logic              op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WAY_W-1:0]  way0,
    input  logic              req1,
    input  logic              op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WAY_W-1:0]  way1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              vld0,
    output logic              vld1,
    output logic [WAY_W-1:0]  victim0,
    output logic [WAY_W-1:0]  victim1,
    output logic [ADDR_W-1:0] lru_addr,
    output logic [WAY_W-1:0]  lru_used_index,
    output logic              lru_enable_write,
    input  logic [WAY_W-1:0]  lru_least_used_index,
    output logic              busy
);

    // Handshake: reqN is held until gntN pulses; a VICTIM answers with a vldN pulse the next cycle.
    typedef enum logic {
        IDLE = 1'b0,
        VWR  = 1'b1
    } state_t;

    localparam logic OP_VICTIM = 1'b1;

    state_t              state_q, state_d;
    logic                vport_q;
    logic [ADDR_W-1:0]   vaddr_q;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [WAY_W-1:0]    used_hold_q;
    logic [WAY_W-1:0]    victim0_q, victim1_q;

    logic                grant;
    logic                winner;
    logic                w_op;
    logic [ADDR_W-1:0]   w_addr;
    logic [WAY_W-1:0]    w_way;

`ifdef CACHE_LRU_SCHED_FIXED_PRIO_EN
    always_comb begin
        winner = ~req0;
    end
`else
    logic rr_ptr_q;
    logic rr_req;

    // The rr_ptr port wins when it requests; otherwise the other port may take the slot.
    always_comb begin
        rr_req = rr_ptr_q ? req1 : req0;
        winner = rr_req ? rr_ptr_q : ~rr_ptr_q;
    end
`endif

    always_comb begin
        w_op   = winner ? op1   : op0;
        w_addr = winner ? addr1 : addr0;
        w_way  = winner ? way1  : way0;
        grant  = (state_q == IDLE) && (req0 || req1) && main_rst_n;
    end

    always_comb begin
        state_d          = state_q;
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        vld0             = 1'b0;
        vld1             = 1'b0;
        victim0          = victim0_q;
        victim1          = victim1_q;
        lru_addr         = addr_hold_q;
        lru_used_index   = used_hold_q;
        lru_enable_write = 1'b0;
        busy             = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    gnt0     = ~winner;
                    gnt1     = winner;
                    lru_addr = w_addr;
                    if (w_op == OP_VICTIM) begin
                        state_d = VWR;
                    end else begin
                        lru_used_index   = w_way;
                        lru_enable_write = 1'b1;
                    end
                end
            end
            VWR: begin
                busy             = 1'b1;
                vld0             = ~vport_q;
                vld1             = vport_q;
                if (vport_q) victim1 = lru_least_used_index;
                else         victim0 = lru_least_used_index;
                // Write the victim back as most-recently-used in the same cycle it is reported.
                lru_addr         = vaddr_q;
                lru_used_index   = lru_least_used_index;
                lru_enable_write = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!main_rst_n) begin
            state_d          = IDLE;
            gnt0             = 1'b0;
            gnt1             = 1'b0;
            vld0             = 1'b0;
            vld1             = 1'b0;
            victim0          = '0;
            victim1          = '0;
            lru_addr         = '0;
            lru_used_index   = '0;
            lru_enable_write = 1'b0;
            busy             = 1'b0;
        end
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q     <= IDLE;
            vport_q     <= 1'b0;
            vaddr_q     <= '0;
            addr_hold_q <= '0;
            used_hold_q <= '0;
            victim0_q   <= '0;
            victim1_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_hold_q <= lru_addr;
            used_hold_q <= lru_used_index;
            victim0_q   <= victim0;
            victim1_q   <= victim1;
            if (grant && (w_op == OP_VICTIM)) begin
                vaddr_q <= w_addr;
                vport_q <= winner;
            end
        end
    end

`ifndef CACHE_LRU_SCHED_FIXED_PRIO_EN
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (grant) begin
            rr_ptr_q <= ~winner;
        end
    end
`endif

endmodule
